// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu: single-outstanding instruction fetch unit owning the PC; YSYX_22050039_IFU_MISALIGN_CHK_EN enables the misaligned-redirect trap (ERR state, fetch_err)
module ysyx_22050039_ifu #(
    parameter int                XLEN     = 64,
    parameter int                INST_LEN = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     pc,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     dnpc,
    input  logic                halt,
    output logic                fetch_err
);
    typedef enum logic [2:0] {
        S_REQ, S_WAIT, S_HOLD, S_HALT
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
        , S_ERR
`endif
    } state_t;
    state_t              state_q;
    logic [XLEN-1:0]     pc_q;
    logic [XLEN-1:0]     pc_d;
    logic [INST_LEN-1:0] inst_q;
    logic                req_valid_q;
    logic                inst_valid_q;
    logic                misalign;
    assign pc_d = pc_wen ? dnpc : pc_q + XLEN'(4);
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
    logic err_q;
    assign misalign  = pc_wen && (dnpc[1:0] != 2'b00);
    assign fetch_err = err_q;
`else
    assign misalign  = 1'b0;
    assign fetch_err = 1'b0;
`endif
    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    // fetch FSM: request -> wait for response -> hold for decoder -> advance or stop
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_REQ: if (imem_req_ready) begin
                    state_q     <= S_WAIT;
                    req_valid_q <= 1'b0;
                end
                S_WAIT: if (imem_resp_valid) begin
                    state_q      <= S_HOLD;
                    inst_q       <= imem_resp_data;
                    inst_valid_q <= 1'b1;
                end
                S_HOLD: if (inst_ready) begin
                    inst_valid_q <= 1'b0;
                    if (halt) begin
                        state_q <= S_HALT;
                    end else if (misalign) begin
`ifdef YSYX_22050039_IFU_MISALIGN_CHK_EN
                        state_q <= S_ERR;
                        pc_q    <= dnpc;
                        err_q   <= 1'b1;
`endif
                    end else begin
                        state_q     <= S_REQ;
                        pc_q        <= pc_d;
                        req_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
